// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
//
// Purpose:
//   Groups the PLL-facing and system-facing signals of the PLL lock
//   supervisor. The clock and reset stay outside this bundle as plain ports.
//
// Signals:
//   pll_locked  PLL locked indication, asynchronous to refclk
//   relock_req  one-cycle request to re-sequence the PLL (refclk domain)
//   pll_rst     active-high reset to the PLL
//   sys_rst_n   active-low reset for downstream logic
//   lock_ok     high while the supervisor is in RUN
//   lock_fail   high while the supervisor is in FAIL
//   retry_cnt   lock-timeout retries since the last RUN or relock request
//   loss_cnt    saturating count of lock-loss events seen in RUN
//
// Modports:
//   master  the supervisor itself (drives resets and status)
//   slave   the PLL / system side (drives lock and relock request)
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             relock_req;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             lock_ok;
    logic             lock_fail;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output sys_rst_n,
        output lock_ok,
        output lock_fail,
        output retry_cnt,
        output loss_cnt
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst_n,
        input  lock_ok,
        input  lock_fail,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Sequences a PLL out of reset on the 50 MHz reference clock. It pulses the
//   PLL reset, synchronises and debounces the PLL locked flag, and releases
//   the downstream system reset only after lock has been stable for
//   LOCK_STABLE_CYCLES. A lock that never arrives is retried up to
//   MAX_RETRIES times before the block parks in FAIL with the PLL held in
//   reset. Loss of lock in RUN, or a software relock request, restarts the
//   whole sequence.
//
// Ports:
//   refclk  reference clock, the only clock
//   rst_n   asynchronous active-low reset
//   bus     pll_lock_supervisor_if.master
//             in : pll_locked (async), relock_req (sync, one cycle)
//             out: pll_rst, sys_rst_n, lock_ok, lock_fail, retry_cnt, loss_cnt
//
// All outputs are registered and take their reset values asynchronously.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int SYNC_STAGES         = 2,
    parameter int CNT_W               = 8
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    pll_lock_supervisor_if.master  bus
);

    // One shared cycle counter serves all timed states, so it is sized for
    // the longest of the three intervals.
    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LIMIT  = CNT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_DEBOUNCE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CYC_W-1:0]       cyc_cnt;
    logic [CYC_W-1:0]       cyc_cnt_next;
    logic [CNT_W-1:0]       retry_q;
    logic [CNT_W-1:0]       retry_next;
    logic [CNT_W-1:0]       loss_q;
    logic [CNT_W-1:0]       loss_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    logic                   pll_rst_q;
    logic                   sys_rst_n_q;
    logic                   lock_ok_q;
    logic                   lock_fail_q;

    // Plain flop chain on the asynchronous locked flag; lock_s is the last
    // stage, so it trails pll_locked by SYNC_STAGES cycles.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, counters and registered outputs. The outputs are decoded from
    // next_state so they change on the same edge as the state they belong
    // to, and sys_rst_n can never be high together with pll_rst.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_PLL_RST;
            cyc_cnt     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state       <= next_state;
            cyc_cnt     <= cyc_cnt_next;
            retry_q     <= retry_next;
            loss_q      <= loss_next;
            pll_rst_q   <= (next_state == ST_PLL_RST) || (next_state == ST_FAIL);
            sys_rst_n_q <= (next_state == ST_RUN);
            lock_ok_q   <= (next_state == ST_RUN);
            lock_fail_q <= (next_state == ST_FAIL);
        end
    end

    // Next-state logic. Every transition clears the cycle counter. The
    // relock request is applied last so it overrides whatever the current
    // state decided, except that a lock loss counted in the same cycle is
    // kept.
    always_comb begin
        next_state   = state;
        cyc_cnt_next = cyc_cnt;
        retry_next   = retry_q;
        loss_next    = loss_q;

        case (state)
            ST_PLL_RST: begin
                if (cyc_cnt == RST_LAST) begin
                    next_state   = ST_WAIT_LOCK;
                    cyc_cnt_next = '0;
                end else begin
                    cyc_cnt_next = cyc_cnt + CYC_W'(1);
                end
            end

            // Lock is tested before the timeout, so a lock arriving on the
            // very last timeout cycle still wins.
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    next_state   = ST_DEBOUNCE;
                    cyc_cnt_next = '0;
                end else if (cyc_cnt == TIMEOUT_LAST) begin
                    cyc_cnt_next = '0;
                    if (retry_q == RETRY_LIMIT) begin
                        next_state = ST_FAIL;
                    end else begin
                        next_state = ST_PLL_RST;
                        retry_next = retry_q + CNT_W'(1);
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt + CYC_W'(1);
                end
            end

            // A drop during debounce is treated as an unsettled PLL, not a
            // timeout: back to WAIT_LOCK with a fresh timeout window.
            ST_DEBOUNCE: begin
                if (!lock_s) begin
                    next_state   = ST_WAIT_LOCK;
                    cyc_cnt_next = '0;
                end else if (cyc_cnt == STABLE_LAST) begin
                    next_state   = ST_RUN;
                    cyc_cnt_next = '0;
                    retry_next   = '0;
                end else begin
                    cyc_cnt_next = cyc_cnt + CYC_W'(1);
                end
            end

            ST_RUN: begin
                if (!lock_s) begin
                    next_state   = ST_PLL_RST;
                    cyc_cnt_next = '0;
                    if (loss_q != '1) begin
                        loss_next = loss_q + CNT_W'(1);
                    end
                end
            end

            ST_FAIL: begin
                next_state = ST_FAIL;
            end

            default: begin
                next_state   = ST_PLL_RST;
                cyc_cnt_next = '0;
            end
        endcase

        if (bus.relock_req) begin
            next_state   = ST_PLL_RST;
            cyc_cnt_next = '0;
            retry_next   = '0;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.lock_ok   = lock_ok_q;
    assign bus.lock_fail = lock_fail_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Purpose:
//   Directed bench for pll_lock_supervisor with short timing parameters
//   (pulse 4, timeout 20, stable 8, 2 retries, 2 sync stages). Expected
//   values are hand-derived cycle counts measured from the rst_n release
//   (or from the relevant input change).
//
// Inputs are changed and outputs are sampled on the falling edge of refclk.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int RST_PULSE_CYCLES    = 4;
    localparam int LOCK_TIMEOUT_CYCLES = 20;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES         = 2;
    localparam int SYNC_STAGES         = 2;
    localparam int CNT_W               = 8;

    logic refclk;
    logic rst_n;
    int   checks;
    int   errors;

    pll_lock_supervisor_if #(.CNT_W(CNT_W)) bus ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (RST_PULSE_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .MAX_RETRIES        (MAX_RETRIES),
        .SYNC_STAGES        (SYNC_STAGES),
        .CNT_W              (CNT_W)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic locked_v,
                                 input logic relock_v);
        rst_n          = rst_v;
        bus.pll_locked = locked_v;
        bus.relock_req = relock_v;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // Holds reset for a few cycles and releases it on a falling edge, so the
    // next rising edge is edge 1 of the new sequence.
    task automatic resetDut(input logic locked_v);
        applyStimulus(1'b0, locked_v, 1'b0);
        stepCycles(3);
        rst_n = 1'b1;
    endtask

    logic exp_rst;
    logic exp_fail;
    int   exp_retry;

    initial begin
        checks = 0;
        errors = 0;
        @(negedge refclk);

        // ---- Reset values, then power-up with lock already present ----
        resetDut(1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset pll_rst",   32'(bus.pll_rst),   32'd1);
        checkOutput("reset sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
        checkOutput("reset lock_ok",   32'(bus.lock_ok),   32'd0);
        checkOutput("reset lock_fail", 32'(bus.lock_fail), 32'd0);
        checkOutput("reset retry_cnt", 32'(bus.retry_cnt), 32'd0);
        checkOutput("reset loss_cnt",  32'(bus.loss_cnt),  32'd0);
        @(negedge refclk);
        rst_n = 1'b1;

        stepCycles(3);
        checkOutput("pwr pll_rst e3", 32'(bus.pll_rst), 32'd1);
        stepCycles(1);
        checkOutput("pwr pll_rst e4", 32'(bus.pll_rst), 32'd0);
        stepCycles(8);
        checkOutput("pwr sys_rst_n e12", 32'(bus.sys_rst_n), 32'd0);
        stepCycles(1);
        checkOutput("pwr sys_rst_n e13", 32'(bus.sys_rst_n), 32'd1);
        checkOutput("pwr lock_ok e13",   32'(bus.lock_ok),   32'd1);
        checkOutput("pwr retry_cnt",     32'(bus.retry_cnt), 32'd0);

        // ---- Lock loss in RUN ----
        bus.pll_locked = 1'b0;
        stepCycles(2);
        checkOutput("loss sys_rst_n +2", 32'(bus.sys_rst_n), 32'd1);
        stepCycles(1);
        checkOutput("loss sys_rst_n +3", 32'(bus.sys_rst_n), 32'd0);
        checkOutput("loss lock_ok +3",   32'(bus.lock_ok),   32'd0);
        checkOutput("loss loss_cnt",     32'(bus.loss_cnt),  32'd1);
        checkOutput("loss pll_rst +3",   32'(bus.pll_rst),   32'd1);
        bus.pll_locked = 1'b1;
        stepCycles(3);
        checkOutput("loss pll_rst +6", 32'(bus.pll_rst), 32'd1);
        stepCycles(1);
        checkOutput("loss pll_rst +7", 32'(bus.pll_rst), 32'd0);
        stepCycles(9);
        checkOutput("loss rerun lock_ok", 32'(bus.lock_ok), 32'd1);

        // ---- Asynchronous reset in RUN ----
        rst_n = 1'b0;
        #1;
        checkOutput("async run pll_rst",   32'(bus.pll_rst),   32'd1);
        checkOutput("async run sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
        checkOutput("async run lock_ok",   32'(bus.lock_ok),   32'd0);
        checkOutput("async run loss_cnt",  32'(bus.loss_cnt),  32'd0);

        // ---- One-cycle glitch at debounce count 5 ----
        resetDut(1'b1);
        stepCycles(8);
        bus.pll_locked = 1'b0;
        stepCycles(1);
        bus.pll_locked = 1'b1;
        stepCycles(4);
        checkOutput("glitch sys_rst_n e13", 32'(bus.sys_rst_n), 32'd0);
        checkOutput("glitch pll_rst e13",   32'(bus.pll_rst),   32'd0);
        stepCycles(6);
        checkOutput("glitch sys_rst_n e19", 32'(bus.sys_rst_n), 32'd0);
        stepCycles(1);
        checkOutput("glitch sys_rst_n e20", 32'(bus.sys_rst_n), 32'd1);
        checkOutput("glitch retry_cnt",     32'(bus.retry_cnt), 32'd0);

        // ---- Asynchronous reset in DEBOUNCE ----
        resetDut(1'b1);
        stepCycles(7);
        checkOutput("async deb pll_rst pre", 32'(bus.pll_rst), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("async deb pll_rst",   32'(bus.pll_rst),   32'd1);
        checkOutput("async deb sys_rst_n", 32'(bus.sys_rst_n), 32'd0);

        // ---- Lock arriving on the last timeout cycle wins ----
        resetDut(1'b0);
        stepCycles(21);
        bus.pll_locked = 1'b1;
        stepCycles(3);
        checkOutput("edge pll_rst e24",   32'(bus.pll_rst),   32'd0);
        checkOutput("edge retry_cnt e24", 32'(bus.retry_cnt), 32'd0);
        stepCycles(8);
        checkOutput("edge sys_rst_n e32", 32'(bus.sys_rst_n), 32'd1);

        // ---- Lock stuck low: two retries, then FAIL ----
        resetDut(1'b0);
        for (int c = 1; c <= 90; c++) begin
            stepCycles(1);
            exp_rst   = (c <= 3) || (c >= 24 && c <= 27) ||
                        (c >= 48 && c <= 51) || (c >= 72);
            exp_retry = (c < 24) ? 0 : ((c < 48) ? 1 : 2);
            exp_fail  = (c >= 72);
            checkOutput($sformatf("stuck e%0d pll_rst", c),   32'(bus.pll_rst),   32'(exp_rst));
            checkOutput($sformatf("stuck e%0d retry_cnt", c), 32'(bus.retry_cnt), 32'(exp_retry));
            checkOutput($sformatf("stuck e%0d lock_fail", c), 32'(bus.lock_fail), 32'(exp_fail));
            checkOutput($sformatf("stuck e%0d sys_rst_n", c), 32'(bus.sys_rst_n), 32'd0);
        end

        // ---- Relock request out of FAIL ----
        bus.relock_req = 1'b1;
        stepCycles(1);
        bus.relock_req = 1'b0;
        bus.pll_locked = 1'b1;
        checkOutput("relock lock_fail", 32'(bus.lock_fail), 32'd0);
        checkOutput("relock retry_cnt", 32'(bus.retry_cnt), 32'd0);
        checkOutput("relock pll_rst +0", 32'(bus.pll_rst),  32'd1);
        stepCycles(3);
        checkOutput("relock pll_rst +3", 32'(bus.pll_rst),  32'd1);
        stepCycles(1);
        checkOutput("relock pll_rst +4", 32'(bus.pll_rst),  32'd0);
        stepCycles(8);
        checkOutput("relock sys_rst_n +12", 32'(bus.sys_rst_n), 32'd0);
        stepCycles(1);
        checkOutput("relock sys_rst_n +13", 32'(bus.sys_rst_n), 32'd1);
        checkOutput("relock lock_ok +13",   32'(bus.lock_ok),   32'd1);

        // ---- Relock request coinciding with lock loss ----
        bus.pll_locked = 1'b0;
        stepCycles(2);
        bus.relock_req = 1'b1;
        stepCycles(1);
        bus.relock_req = 1'b0;
        bus.pll_locked = 1'b1;
        checkOutput("both loss_cnt",  32'(bus.loss_cnt),  32'd1);
        checkOutput("both pll_rst",   32'(bus.pll_rst),   32'd1);
        checkOutput("both sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
        stepCycles(13);
        checkOutput("both rerun lock_ok", 32'(bus.lock_ok), 32'd1);

        // ---- loss_cnt saturation ----
        for (int i = 2; i <= 257; i++) begin
            bus.pll_locked = 1'b0;
            stepCycles(3);
            bus.pll_locked = 1'b1;
            stepCycles(13);
            checkOutput($sformatf("sat loss_cnt %0d", i), 32'(bus.loss_cnt),
                        (i > 255) ? 32'd255 : 32'(i));
        end
        checkOutput("sat lock_ok", 32'(bus.lock_ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
